// File: rtl/gpio_debounce.sv
// gpio_debounce: 2-flop synchroniser and per-bit stability counter.
// Rise/fall pulse registers exist only when GPIO_DEBOUNCE_EDGE_EN is defined.
module gpio_debounce #(
   parameter int gpio_w = 8,
   parameter int cnt_w  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [cnt_w-1:0]  thresh,
   input  logic [gpio_w-1:0] gpi_raw,
   output logic [gpio_w-1:0] gpi_clean,
   output logic [gpio_w-1:0] rise,
   output logic [gpio_w-1:0] fall
);

   localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

   logic [gpio_w-1:0] s1;
   logic [gpio_w-1:0] s2;
   logic [gpio_w-1:0] mism;
   logic [gpio_w-1:0] commit;

   // bring the pad levels into the clk domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= gpi_raw;
         s2 <= s1;
      end
   end

   assign mism = s2 ^ gpi_clean;

   for (genvar i = 0; i < gpio_w; i++) begin : g_bit
      logic [cnt_w-1:0] cnt;

      // commit once the mismatch has held for thresh counted edges
      assign commit[i] = mism[i] && (cnt >= thresh);

      // count while mismatched; a match or a commit clears the count
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            cnt <= '0;
         end else if (mism[i] && !commit[i]) begin
            cnt <= cnt + cnt_one;
         end else begin
            cnt <= '0;
         end
      end
   end

   // clean level flips exactly on the bits that commit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gpi_clean <= '0;
      end else begin
         gpi_clean <= gpi_clean ^ commit;
      end
   end

`ifdef GPIO_DEBOUNCE_EDGE_EN
   // one-cycle pulses aligned with the first cycle of the new level
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise <= '0;
         fall <= '0;
      end else begin
         rise <= commit & s2;
         fall <= commit & ~s2;
      end
   end
`else
   assign rise = '0;
   assign fall = '0;
`endif

endmodule

// File: tb/tb_gpio_debounce.sv
// tb_gpio_debounce: directed plan scenarios plus random stimulus,
// scored against a streak-length reference model through a queue.
module tb_gpio_debounce;

   localparam int W  = 8;
   localparam int CW = 16;
`ifdef GPIO_DEBOUNCE_EDGE_EN
   localparam bit edge_en = 1'b1;
`else
   localparam bit edge_en = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [CW-1:0] thresh;
   logic [W-1:0]  gpi_raw;
   logic [W-1:0]  gpi_clean;
   logic [W-1:0]  rise;
   logic [W-1:0]  fall;

   int tests = 0;
   int fails = 0;

   typedef struct packed {
      logic [W-1:0] clean;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } exp_t;

   exp_t sbq[$];

   logic [W-1:0] m_clean;
   logic [W-1:0] m_dq[$];
   int           m_streak[W];

   always #5 clk = ~clk;

   gpio_debounce #(
      .gpio_w(W),
      .cnt_w (CW)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .thresh   (thresh),
      .gpi_raw  (gpi_raw),
      .gpi_clean(gpi_clean),
      .rise     (rise),
      .fall     (fall)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   // Reference: s2 is the raw value sampled two edges earlier. A bit
   // commits when the number of consecutive mismatching edges,
   // including this one, exceeds the threshold seen at this edge.
   function automatic void model_step(input logic [W-1:0] raw,
                                      input int thr, input logic r);
      exp_t         e;
      logic [W-1:0] s2v;
      e = '0;
      if (r) begin
         m_clean = '0;
         m_dq.delete();
         m_dq.push_back('0);
         m_dq.push_back('0);
         for (int i = 0; i < W; i++) m_streak[i] = 0;
      end else begin
         s2v = m_dq.pop_front();
         m_dq.push_back(raw);
         for (int i = 0; i < W; i++) begin
            if (s2v[i] != m_clean[i]) begin
               m_streak[i]++;
               if (m_streak[i] > thr) begin
                  m_clean[i]  = s2v[i];
                  m_streak[i] = 0;
                  if (edge_en) begin
                     if (s2v[i]) e.rise[i] = 1'b1;
                     else        e.fall[i] = 1'b1;
                  end
               end
            end else begin
               m_streak[i] = 0;
            end
         end
      end
      e.clean = m_clean;
      sbq.push_back(e);
   endfunction

   // drive on the falling edge, then return just after the rising edge
   task automatic step(input logic [W-1:0] raw, input int thr,
                       input logic r);
      @(negedge clk);
      gpi_raw = raw;
      thresh  = CW'(thr);
      rst     = r;
      model_step(raw, thr, r);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      repeat (2) step('0, 0, 1'b1);
   endtask

   // monitor: compare each edge's outputs with the queued expectation
   always @(posedge clk) begin : mon
      exp_t e;
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         chk("sb_clean", gpi_clean, e.clean);
         chk("sb_rise", rise, e.rise);
         chk("sb_fall", fall, e.fall);
         chk("sb_excl", rise & fall, 0);
      end
   end

   initial begin : stim
      logic [W-1:0] lvl;
      logic [W-1:0] raw;
      int           thr;
      rst     = 1'b1;
      gpi_raw = '0;
      thresh  = '0;

      // reset with pads high, then release with thresh = 3
      repeat (3) begin
         step(8'hFF, 3, 1'b1);
         chk("rst_clean", gpi_clean, 0);
         chk("rst_rise", rise, 0);
         chk("rst_fall", fall, 0);
      end
      for (int k = 1; k <= 7; k++) begin
         step(8'hFF, 3, 1'b0);
         chk("rel_clean", gpi_clean, (k >= 6) ? 8'hFF : 8'h00);
         chk("rel_rise", rise, (edge_en && k == 6) ? 8'hFF : 8'h00);
      end

      // glitch of 5 samples with thresh = 5 is rejected
      do_reset();
      for (int k = 1; k <= 30; k++) begin
         step((k <= 5) ? 8'h04 : 8'h00, 5, 1'b0);
         chk("glitch", {gpi_clean[2], rise[2], fall[2]}, 0);
      end

      // qualify for 10 cycles then release
      do_reset();
      for (int k = 1; k <= 25; k++) begin
         step((k <= 10) ? 8'h04 : 8'h00, 5, 1'b0);
         chk("qual_clean", gpi_clean[2], (k >= 8 && k < 18));
         chk("qual_rise", rise[2], (edge_en && k == 8));
         chk("qual_fall", fall[2], (edge_en && k == 18));
      end

      // zero threshold, bits 0 and 7 toggling opposite ways
      do_reset();
      repeat (4) step(8'h80, 0, 1'b0);
      chk("zt_pre", gpi_clean, 8'h80);
      for (int k = 1; k <= 4; k++) begin
         step(8'h01, 0, 1'b0);
         chk("zt_clean", gpi_clean, (k >= 3) ? 8'h01 : 8'h80);
         chk("zt_rise", rise, (edge_en && k == 3) ? 8'h01 : 8'h00);
         chk("zt_fall", fall, (edge_en && k == 3) ? 8'h80 : 8'h00);
      end

      // threshold lowered from 100 to 10 after 20 counted edges
      do_reset();
      for (int k = 1; k <= 24; k++) begin
         step(8'h02, (k < 23) ? 100 : 10, 1'b0);
         chk("thr_low", gpi_clean[1], (k >= 23));
      end

      // random levels, glitches, threshold changes and resets
      do_reset();
      lvl = '0;
      thr = 2;
      for (int n = 0; n < 4000; n++) begin
         if (n % 250 == 0) thr = int'($urandom_range(0, 6));
         for (int b = 0; b < W; b++)
            if ($urandom_range(0, 11) == 0) lvl[b] = ~lvl[b];
         raw = lvl;
         if ($urandom_range(0, 40) == 0) begin
            int g;
            g = int'($urandom_range(0, W - 1));
            raw[g] = ~raw[g];
         end
         step(raw, thr, ($urandom_range(0, 599) == 0));
      end

      step(lvl, thr, 1'b0);
      @(negedge clk);
      chk("sb_drain", sbq.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/gpio_debounce.md
# gpio_debounce

Input conditioning stage that sits directly upstream of the GPIO peripheral's `gpi` port. Each raw pad input is synchronised into the `clk` domain, debounced by a per-bit programmable stability counter, and presented as a clean level, along with optional single-cycle rise and fall pulses. Glitches shorter than the programmed threshold never reach the GPIO register file or its interrupt logic.

## Interface

Parameters:
- `gpio_w`, 8, number of input bits; must match the downstream GPIO width.
- `cnt_w`, 16, width of the per-bit stability counter and of the threshold input.

Ports:
- `clk`  in  1  clock; all logic is on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `thresh`  in  cnt_w  debounce threshold in `clk` cycles. It is quasi-static and is sampled live every cycle.
- `gpi_raw`  in  gpio_w  asynchronous pad inputs.
- `gpi_clean`  out  gpio_w  debounced, registered level; connects to the GPIO `gpi` port.
- `rise`  out  gpio_w  one-cycle pulse per bit on a clean 0->1 transition.
- `fall`  out  gpio_w  one-cycle pulse per bit on a clean 1->0 transition.

## Operation

- **Reset values.** While `rst` is high, all of the following are 0: both synchroniser flops, every counter, `gpi_clean`, `rise` and `fall`.
- **Synchroniser.** Each bit passes through two flops: `gpi_raw` -> `s1` -> `s2`. Only `s2` is used downstream; the two flops have no other function.
- **Per-bit state.** Each bit is handled independently. There is no shared state between bits.
- **Mismatch, count below threshold.** If `s2 != gpi_clean` and `cnt < thresh`, then `cnt <= cnt + 1`.
- **Mismatch, count reached.** If `s2 != gpi_clean` and `cnt >= thresh`, then:
  - `gpi_clean <= s2`
  - `cnt <= 0`
  - the matching `rise` or `fall` bit is 1 in the same cycle that `gpi_clean` changes.
- **Match.** If `s2 == gpi_clean`, then `cnt <= 0`. Any partial count is discarded, so a glitch restarts qualification from zero.
- **Counter range.** The counter never exceeds `thresh`, so it cannot wrap.
- **Lowering `thresh` mid-count.** Because the compare is `>=`, a counter already at or above the new value commits on the next edge.
- **`thresh = 0`.** A mismatch commits on the first edge at which it is seen; this is pure synchronisation with no filtering.
- **`thresh` at its maximum.** `thresh = 2^cnt_w - 1` is legal. The counter reaches it without overflow.
- **Pulse outputs.** `rise` and `fall` are registered. They are never both 1 for the same bit, and are 0 in every cycle where `gpi_clean` does not change.
- **Start-up edge.** If `gpi_raw` is high when reset is released, that bit produces one `rise` pulse after the normal latency. This start-up edge is intended, and downstream logic must tolerate it.

## Timing

- **Latency.** Let edge 1 be the first rising edge that samples a changed `gpi_raw`. If the input then stays stable, `gpi_clean` changes after rising edge `thresh + 3`. Examples: `thresh = 0` changes at edge 3; `thresh = 4` changes at edge 7.
- **Minimum pulse width.** The shortest raw level that propagates is `thresh + 1` consecutive samples of `s2` at the new value.
- **Rejected glitches.** Any shorter excursion produces no change on `gpi_clean`, `rise` or `fall`.
- **Pulse width.** `rise` and `fall` are high for exactly one cycle, aligned with the first cycle of the new `gpi_clean` value.
- **Reset mid-count.** Asserting `rst` clears state immediately (asynchronously). No pulse is emitted and counting restarts from 0 after release.
- **Reset release.** Release is synchronous to `clk` by system convention; the block adds no reset synchroniser.

## Configuration

- Macro: `GPIO_DEBOUNCE_EDGE_EN`.
- **Defined:** the `rise` and `fall` registers and logic are built as described above.
- **Undefined:** `rise` and `fall` are tied to 0 and no edge registers are synthesised. `gpi_clean` behaviour and latency are unchanged.

## Test plan

All scenarios use `gpio_w = 8` and `cnt_w = 16` unless stated.

- **Reset.** Hold `rst` high with `gpi_raw = 8'hFF`; all outputs must read 0. Release with `thresh = 3`: `gpi_clean` must become 8'hFF at edge 6, and `rise` must be 8'hFF for exactly that one cycle.
- **Glitch rejection.** Set `thresh = 5`; pulse bit 2 high for 5 cycles, then low. `gpi_clean[2]`, `rise[2]` and `fall[2]` must stay 0 throughout.
- **Qualify then release.** Set `thresh = 5`; hold bit 2 high for 10 cycles, then low. `gpi_clean[2]` must rise at edge 8 with a one-cycle `rise[2]`. After the drop, it must fall 8 edges later with a one-cycle `fall[2]`.
- **Independent bits and zero threshold.** Set `thresh = 0`; toggle bits 0 and 7 in opposite directions in the same cycle. Both must update at edge 3, with `rise[0]` and `fall[7]` asserted together.
- **Threshold lowered mid-count.** Set `thresh = 100`; start a mismatch on bit 1. After 20 counted cycles, write `thresh = 10`. `gpi_clean[1]` must update on the very next edge.
- **Macro undefined.** Build without `GPIO_DEBOUNCE_EDGE_EN` and repeat the qualify-then-release scenario. `gpi_clean` timing must be identical, and `rise` and `fall` must stay 0 for the whole run.
